msu_data_buf: RTL and testbench

// - MSU-1 data staging buffer: simple dual-port RAM, 16384 x 8 bit.
// - Port A (write) is filled by the MCU program/DMA path with data-file contents.
// - Port B (read) feeds the SNES-visible MSU data register; the MSU core advances addrb on each data read.
// - Sits between the MCU load interface and the msu register block, inferred as block RAM.

---
 rtl/msu_pkg.sv | 10 +
 rtl/sdp_ram_core.sv | 38 +++
 rtl/msu_data_buf.sv | 54 +++++
 tb/tb_msu_data_buf.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/msu_pkg.sv
// Shared MSU definitions: data staging buffer geometry and bus types.
package msu_pkg;

    localparam int unsigned MSU_BUF_AW = 14;
    localparam int unsigned MSU_BUF_DW = 8;

    typedef logic [MSU_BUF_AW-1:0] msu_buf_addr_t;
    typedef logic [MSU_BUF_DW-1:0] msu_buf_data_t;

endpackage

// File: rtl/sdp_ram_core.sv
// Generic simple dual-port RAM, one clock, read-first registered read.
// Ports:
//   clk      - clock for both ports
//   we       - write enable
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address, sampled every edge
//   rd_data  - registered read data (old contents on same-address write)
module sdp_ram_core #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // No reset on the array or its read register so it maps onto block RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; nonblocking semantics give read-first on a collision.
    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/msu_data_buf.sv
// MSU-1 data staging buffer: 16K x 8 simple dual-port RAM between the MCU
// load path (port A) and the SNES-visible MSU data register (port B).
// Ports:
//   clkin  - single clock for both ports
//   rst    - asynchronous active-high reset (clears doutb only)
//   wea    - port A write enable
//   addra  - port A write address
//   dina   - port A write data
//   addrb  - port B read address
//   doutb  - port B read data, one cycle after addrb
module msu_data_buf
    import msu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = MSU_BUF_AW,
    parameter int unsigned DATA_WIDTH = MSU_BUF_DW
) (
    input  logic                  clkin,
    input  logic                  rst,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    input  logic [ADDR_WIDTH-1:0] addrb,
    output logic [DATA_WIDTH-1:0] doutb
);

    logic [DATA_WIDTH-1:0] ram_q;
    logic                  out_en;

    sdp_ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clkin),
        .we      (wea),
        .wr_addr (addra),
        .wr_data (dina),
        .rd_addr (addrb),
        .rd_data (ram_q)
    );

    // Async-reset qualifier for the RAM output register: drops doutb to zero
    // the instant rst rises, and re-arms on the first edge after release,
    // which is the same edge that loads mem[addrb] into ram_q.
    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    assign doutb = out_en ? ram_q : '0;

endmodule

// File: tb/tb_msu_data_buf.sv
module tb_msu_data_buf;

    localparam int unsigned AW    = 14;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clkin = 1'b0;
    logic          rst   = 1'b1;
    logic          wea   = 1'b0;
    logic [AW-1:0] addra = '0;
    logic [DW-1:0] dina  = '0;
    logic [AW-1:0] addrb = '0;
    logic [DW-1:0] doutb;

    int applied     = 0;
    int miscompares = 0;

    logic [DW-1:0] model [DEPTH];

    typedef struct {
        logic          wea;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        logic [AW-1:0] addrb;
        logic [DW-1:0] exp;
    } vec_t;

    msu_data_buf dut (
        .clkin (clkin),
        .rst   (rst),
        .wea   (wea),
        .addra (addra),
        .dina  (dina),
        .addrb (addrb),
        .doutb (doutb)
    );

    always #5 clkin = ~clkin;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: doutb=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clkin);
        #1;
    endtask

    // Drive one cycle, keep the model in step (read-first), check doutb.
    task automatic cycle(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra, input logic [DW-1:0] exp, input string name);
        wea = w; addra = wa; dina = wd; addrb = ra;
        if (w) model[wa] = wd;
        step();
        check(name, doutb, exp);
    endtask

    initial begin
        vec_t vecs[13];
        logic [AW-1:0] a;
        logic [DW-1:0] e;

        vecs[0]  = '{1'b1, 14'h0000, 8'h53, 14'h0000, 8'h00};
        vecs[1]  = '{1'b1, 14'h0001, 8'h2D, 14'h0000, 8'h53};
        vecs[2]  = '{1'b1, 14'h3FFF, 8'h31, 14'h0001, 8'h2D};
        vecs[3]  = '{1'b0, 14'h0000, 8'h00, 14'h3FFF, 8'h31};
        vecs[4]  = '{1'b0, 14'h0000, 8'h00, 14'h0000, 8'h53};
        vecs[5]  = '{1'b1, 14'h0100, 8'h11, 14'h3FFF, 8'h31};
        vecs[6]  = '{1'b1, 14'h0100, 8'h22, 14'h0100, 8'h11};
        vecs[7]  = '{1'b0, 14'h0100, 8'hFF, 14'h0100, 8'h22};
        vecs[8]  = '{1'b0, 14'h0100, 8'h00, 14'h0100, 8'h22};
        vecs[9]  = '{1'b1, 14'h1234, 8'h7E, 14'h0001, 8'h2D};
        vecs[10] = '{1'b1, 14'h0000, 8'hA5, 14'h1234, 8'h7E};
        vecs[11] = '{1'b0, 14'h0000, 8'h5A, 14'h0000, 8'hA5};
        vecs[12] = '{1'b0, 14'h0000, 8'hC3, 14'h0000, 8'hA5};

        // Reset state, with an edge under reset.
        #2;
        check("reset_init", doutb, 8'h00);
        step();
        check("reset_held", doutb, 8'h00);

        // Clear the whole array so the model starts from known contents.
        #2 rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            wea = 1'b1; addra = AW'(i); dina = '0; addrb = '0;
            model[i] = '0;
            step();
        end

        // Directed table: writes, 0x3FFF boundary, collision, wea=0 with dina toggling.
        for (int i = 0; i < 13; i++) begin
            cycle(vecs[i].wea, vecs[i].addra, vecs[i].dina, vecs[i].addrb, vecs[i].exp,
                  $sformatf("vec%0d", i));
        end

        // Async reset mid-cycle while doutb=0xA5; write accepted during reset.
        #2 rst = 1'b1;
        #1 check("async_rst", doutb, 8'h00);
        wea = 1'b1; addra = 14'h0002; dina = 8'h44; addrb = 14'h1234;
        model[14'h0002] = 8'h44;
        step();
        check("rst_edge", doutb, 8'h00);
        wea = 1'b0;
        #2 rst = 1'b0;
        #1 check("rst_release", doutb, 8'h00);
        step();
        check("retain_1234", doutb, 8'h7E);
        cycle(1'b0, 14'h0000, 8'h00, 14'h0002, 8'h44, "write_in_rst");

        // Sequential stream across 0x1FF0..0x200F, then sweep with 1-cycle lag.
        for (int i = 0; i < 32; i++) begin
            a = AW'(14'h1FF0 + i);
            wea = 1'b1; addra = a; dina = a[7:0]; addrb = 14'h0000;
            model[a] = a[7:0];
            step();
        end
        wea = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a = AW'(14'h1FF0 + i);
            e = a[7:0];
            cycle(1'b0, 14'h0000, 8'h00, a, e, $sformatf("stream_%h", a));
        end
        // Pointer wrap 0x3FFF -> 0x0000.
        cycle(1'b0, 14'h0000, 8'h00, 14'h3FFF, 8'h31, "wrap_3fff");
        cycle(1'b0, 14'h0000, 8'h00, 14'h0000, 8'hA5, "wrap_0000");

        // Random read/write against the read-first model; narrow window half the time for collisions.
        for (int i = 0; i < 10000; i++) begin
            logic          w;
            logic [AW-1:0] wa, ra;
            logic [DW-1:0] wd;
            w  = 1'($urandom_range(0, 1));
            wd = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                wa = AW'($urandom_range(0, 15) + 14'h3FF8);
                ra = AW'($urandom_range(0, 15) + 14'h3FF8);
            end else begin
                wa = AW'($urandom);
                ra = AW'($urandom);
            end
            e = model[ra];
            cycle(w, wa, wd, ra, e, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
